// File: rtl/mux2_arb_pkg.sv
// Shared types and constants for the two-requester round-robin mux arbiter.
package mux2_arb_pkg;

   typedef logic [1:0] state_t;

   localparam state_t IDLE  = 2'd0;
   localparam state_t GNT_A = 2'd1;
   localparam state_t GNT_B = 2'd2;

   localparam logic REQ_A = 1'b0;
   localparam logic REQ_B = 1'b1;

   localparam int unsigned DEFAULT_MAX_HOLD = 8;

endpackage

// File: rtl/mux2_arbiter_if.sv
// Request/grant/data bundle between the two requesters and the mux arbiter.
interface mux2_arbiter_if;

   logic req_a;
   logic req_b;
   logic a;
   logic b;
   logic gnt_a;
   logic gnt_b;
   logic sel;
   logic y;
   logic busy;

   modport master (
      output req_a, req_b, a, b,
      input  gnt_a, gnt_b, sel, y, busy
   );

   modport slave (
      input  req_a, req_b, a, b,
      output gnt_a, gnt_b, sel, y, busy
   );

endinterface

// File: rtl/mux2_hold_ctr.sv
// Counts contended cycles of the current grant; at_limit flags the last allowed one.
module mux2_hold_ctr
   import mux2_arb_pkg::*;
#(
   parameter int unsigned MAX_HOLD = DEFAULT_MAX_HOLD
) (
   input  logic clk,
   input  logic rst_n,
   input  logic clear,
   input  logic inc,
   output logic at_limit
);

   // A one-cycle limit needs no count; keep a 1-bit register so the width stays legal.
   localparam int unsigned CW = (MAX_HOLD > 1) ? $clog2(MAX_HOLD) : 1;
   localparam logic [CW-1:0] LIMIT = CW'(MAX_HOLD - 1);

   logic [CW-1:0] cnt_q, cnt_d;

   always_comb begin
      cnt_d = cnt_q;
      if (clear) begin
         cnt_d = '0;
      end else if (inc && (cnt_q != LIMIT)) begin
         cnt_d = cnt_q + 1'b1;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

   assign at_limit = (cnt_q == LIMIT);

endmodule

// File: rtl/mux2_arbiter.sv
// Round-robin arbiter owning a shared 2:1 bit mux, with a starvation hold limit.
// Define MUX2_ARB_STATS_EN to add the saturating switch_cnt output.
module mux2_arbiter
   import mux2_arb_pkg::*;
#(
   parameter int unsigned MAX_HOLD = DEFAULT_MAX_HOLD,
   parameter int unsigned CNT_W    = 16
) (
   input  logic               clk,
   input  logic               rst_n,
`ifdef MUX2_ARB_STATS_EN
   output logic [CNT_W-1:0]   switch_cnt,
`endif
   mux2_arbiter_if.slave      bus
);

   state_t state_q, state_d;
   logic   last_q, last_d;
   logic   y_q, y_d;
   logic   both_req;
   logic   hold_clr;
   logic   hold_inc;
   logic   at_limit;
   logic   entering;

   assign both_req = bus.req_a & bus.req_b;

   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE: begin
            if (both_req) begin
               state_d = (last_q == REQ_B) ? GNT_A : GNT_B;
            end else if (bus.req_a) begin
               state_d = GNT_A;
            end else if (bus.req_b) begin
               state_d = GNT_B;
            end
         end
         GNT_A: begin
            if (!bus.req_a) begin
               state_d = bus.req_b ? GNT_B : IDLE;
            end else if (bus.req_b && at_limit) begin
               state_d = GNT_B;
            end
         end
         GNT_B: begin
            if (!bus.req_b) begin
               state_d = bus.req_a ? GNT_A : IDLE;
            end else if (bus.req_a && at_limit) begin
               state_d = GNT_A;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   assign entering = (state_d != state_q) && (state_d != IDLE);

   always_comb begin
      last_d = last_q;
      if (state_d == GNT_A && state_q != GNT_A) begin
         last_d = REQ_A;
      end else if (state_d == GNT_B && state_q != GNT_B) begin
         last_d = REQ_B;
      end
   end

   // The hold count only means anything while the other side is waiting.
   assign hold_inc = (state_q != IDLE) && both_req;
   assign hold_clr = (state_d != state_q) || !both_req || (state_q == IDLE);

   always_comb begin
      y_d = 1'b0;
      if (state_q == GNT_A) begin
         y_d = bus.a;
      end else if (state_q == GNT_B) begin
         y_d = bus.b;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
         last_q  <= REQ_B;
         y_q     <= 1'b0;
      end else begin
         state_q <= state_d;
         last_q  <= last_d;
         y_q     <= y_d;
      end
   end

   mux2_hold_ctr #(
      .MAX_HOLD (MAX_HOLD)
   ) u_hold_ctr (
      .clk      (clk),
      .rst_n    (rst_n),
      .clear    (hold_clr),
      .inc      (hold_inc),
      .at_limit (at_limit)
   );

   assign bus.gnt_a = (state_q == GNT_A);
   assign bus.gnt_b = (state_q == GNT_B);
   assign bus.sel   = (state_q == GNT_B);
   assign bus.busy  = (state_q == GNT_A) || (state_q == GNT_B);
   assign bus.y     = y_q;

`ifdef MUX2_ARB_STATS_EN
   logic [CNT_W-1:0] switch_cnt_q, switch_cnt_d;

   always_comb begin
      switch_cnt_d = switch_cnt_q;
      if (entering && (switch_cnt_q != {CNT_W{1'b1}})) begin
         switch_cnt_d = switch_cnt_q + 1'b1;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         switch_cnt_q <= '0;
      end else begin
         switch_cnt_q <= switch_cnt_d;
      end
   end

   assign switch_cnt = switch_cnt_q;
`else
   logic unused_entering;
   assign unused_entering = entering;
`endif

endmodule

// File: tb/tb_mux2_arbiter.sv
// Randomised bench for mux2_arbiter at hold limits 8, 4 and 1 against an ownership model.
module tb_mux2_arbiter;

   logic clk;
   logic rst_n;
   logic req_a_t, req_b_t, a_t, b_t;

   int total = 0;
   int bad   = 0;

   mux2_arbiter_if if0 ();
   mux2_arbiter_if if1 ();
   mux2_arbiter_if if2 ();

   assign if0.req_a = req_a_t;
   assign if0.req_b = req_b_t;
   assign if0.a     = a_t;
   assign if0.b     = b_t;
   assign if1.req_a = req_a_t;
   assign if1.req_b = req_b_t;
   assign if1.a     = a_t;
   assign if1.b     = b_t;
   assign if2.req_a = req_a_t;
   assign if2.req_b = req_b_t;
   assign if2.a     = a_t;
   assign if2.b     = b_t;

`ifdef MUX2_ARB_STATS_EN
   logic [1:0] sw_o [3];
`endif

   mux2_arbiter #(.CNT_W(2)) u_dut0 (
      .clk        (clk),
      .rst_n      (rst_n),
`ifdef MUX2_ARB_STATS_EN
      .switch_cnt (sw_o[0]),
`endif
      .bus        (if0)
   );
   mux2_arbiter #(.MAX_HOLD(4), .CNT_W(2)) u_dut1 (
      .clk        (clk),
      .rst_n      (rst_n),
`ifdef MUX2_ARB_STATS_EN
      .switch_cnt (sw_o[1]),
`endif
      .bus        (if1)
   );
   mux2_arbiter #(.MAX_HOLD(1), .CNT_W(2)) u_dut2 (
      .clk        (clk),
      .rst_n      (rst_n),
`ifdef MUX2_ARB_STATS_EN
      .switch_cnt (sw_o[2]),
`endif
      .bus        (if2)
   );

   logic [2:0] ga, gb, sl, yy, bz;
   assign ga = {if2.gnt_a, if1.gnt_a, if0.gnt_a};
   assign gb = {if2.gnt_b, if1.gnt_b, if0.gnt_b};
   assign sl = {if2.sel,   if1.sel,   if0.sel};
   assign yy = {if2.y,     if1.y,     if0.y};
   assign bz = {if2.busy,  if1.busy,  if0.busy};

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // Model: owner 0 = nobody, 1 = A, 2 = B; waited = cycles the other side has waited.
   int   mh [3] = '{8, 4, 1};
   int   own [3];
   int   last [3];
   int   waited [3];
   int   swm [3];
   logic ym [3];

   task automatic check_bit(input string tag, input logic got, input logic exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s: got %b expected %b at %0t", tag, got, exp, $time);
      end
   endtask

   task automatic model_reset();
      for (int k = 0; k < 3; k++) begin
         own[k] = 0; last[k] = 2; waited[k] = 0; swm[k] = 0; ym[k] = 1'b0;
      end
   endtask

   task automatic model_clock();
      for (int k = 0; k < 3; k++) begin
         int   nxt;
         logic other;
         nxt = own[k];
         ym[k] = (own[k] == 1) ? a_t : (own[k] == 2) ? b_t : 1'b0;
         if (own[k] == 0) begin
            if (req_a_t && req_b_t) nxt = (last[k] == 1) ? 2 : 1;
            else if (req_a_t)       nxt = 1;
            else if (req_b_t)       nxt = 2;
         end else begin
            logic mine;
            mine  = (own[k] == 1) ? req_a_t : req_b_t;
            other = (own[k] == 1) ? req_b_t : req_a_t;
            if (!mine) nxt = other ? 3 - own[k] : 0;
            else if (other && waited[k] >= mh[k] - 1) nxt = 3 - own[k];
         end
         other = (own[k] == 1) ? req_b_t : req_a_t;
         if (nxt != own[k] || own[k] == 0 || !other || !(req_a_t && req_b_t)) waited[k] = 0;
         else waited[k]++;
         if (nxt != own[k] && nxt != 0) begin
            last[k] = nxt;
            if (swm[k] < 3) swm[k]++;
         end
         own[k] = nxt;
      end
   endtask

   task automatic check_all(input string ph);
      for (int k = 0; k < 3; k++) begin
         check_bit($sformatf("%s_gnt_a%0d", ph, k), ga[k], own[k] == 1);
         check_bit($sformatf("%s_gnt_b%0d", ph, k), gb[k], own[k] == 2);
         check_bit($sformatf("%s_sel%0d", ph, k),   sl[k], own[k] == 2);
         check_bit($sformatf("%s_busy%0d", ph, k),  bz[k], own[k] != 0);
         check_bit($sformatf("%s_y%0d", ph, k),     yy[k], ym[k]);
`ifdef MUX2_ARB_STATS_EN
         total++;
         if (sw_o[k] !== 2'(swm[k])) begin
            bad++;
            $display("FAIL %s_sw%0d: got %0d expected %0d", ph, k, sw_o[k], swm[k]);
         end
`endif
      end
   endtask

   task automatic step(input logic ra, input logic rb, input logic da, input logic db,
                       input string ph);
      req_a_t = ra; req_b_t = rb; a_t = da; b_t = db;
      @(posedge clk);
      model_clock();
      @(negedge clk);
      check_all(ph);
   endtask

   task automatic do_reset();
      rst_n = 1'b0;
      model_reset();
      for (int i = 0; i < 3; i++) begin
         req_a_t = 1'($urandom); req_b_t = 1'($urandom);
         @(negedge clk);
         check_all("rst");
      end
      req_a_t = 1'b0; req_b_t = 1'b0;
      rst_n = 1'b1;
   endtask

   initial begin
      rst_n = 1'b0; req_a_t = 1'b0; req_b_t = 1'b0; a_t = 1'b0; b_t = 1'b0;
      model_reset();
      @(negedge clk);
      do_reset();
      step(0, 0, 1, 1, "idle");
      step(0, 0, 1, 1, "idle");

      // Lone A, then drop.
      step(1, 0, 1, 0, "single");
      check_bit("single_gnt", ga[0], 1'b1);
      step(1, 0, 1, 0, "single");
      check_bit("single_y", yy[0], 1'b1);
      step(0, 0, 1, 0, "single");
      check_bit("single_drop", ga[0], 1'b0);
      step(0, 0, 1, 0, "single");

      // Tie after reset goes to A, then hands straight to B.
      do_reset();
      step(1, 1, 0, 1, "tie");
      check_bit("tie_first_a", ga[0], 1'b1);
      step(0, 1, 0, 1, "tie");
      check_bit("tie_no_bubble", gb[0], 1'b1);
      step(0, 1, 0, 0, "tie");
      step(0, 0, 0, 0, "tie");

      // Starvation: B raised two cycles into A's grant.
      do_reset();
      step(1, 0, 1, 0, "starve");
      step(1, 0, 1, 0, "starve");
      for (int i = 2; i < 20; i++) begin
         step(1, 1, 1, 0, "starve");
         if (i == 4) check_bit("starve_hold4", ga[1], 1'b1);
         if (i == 5) check_bit("starve_switch4", gb[1], 1'b1);
         if (i == 5) check_bit("starve_hold8", ga[0], 1'b1);
      end

      // Asynchronous reset in the middle of a grant.
      step(1, 0, 1, 1, "async");
      #2 rst_n = 1'b0;
      #1;
      check_bit("async_gnt_a", ga[0], 1'b0);
      check_bit("async_busy", bz[1], 1'b0);
      check_bit("async_y", yy[0], 1'b0);
      model_reset();
      @(negedge clk);
      check_all("async");
      rst_n = 1'b1;

      for (int i = 0; i < 3000; i++) begin
         step($urandom_range(0, 3) != 0, $urandom_range(0, 3) != 0,
              1'($urandom), 1'($urandom), "rand");
         if (i % 700 == 699) do_reset();
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
